// File: rtl/sprite_cmd_dispatcher.sv
// Command FIFO between the HPS Avalon slave and the sprite/tube display components.
// Broadcasts one queued command per clock; buffer-swap words wait at the head for vertical blank.
module sprite_cmd_dispatcher #(
  parameter int FIFO_DEPTH  = 64,
  parameter int LEVEL_W     = 7,
  parameter int VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] CTRL_SWAP = 4'hF;

  typedef enum logic {RUN, WAIT_VB} state_t;

  state_t state, state_next;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic [31:0]        swap_count;

  logic [31:0] head;
  logic [31:0] cmd_next;
  logic [31:0] status_word;
  logic        push_req, flush_req, status_rd;
  logic        full, empty, vblank_hit, head_swap;
  logic        pop, push, drop, swap_inc;

  assign push_req   = chipselect && write && (address == 2'd0);
  assign flush_req  = chipselect && write && (address == 2'd3);
  assign status_rd  = chipselect && read  && (address == 2'd1);
  assign full       = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign head       = mem[rd_ptr];
  assign head_swap  = (head[20:17] == CTRL_SWAP);
  assign vblank_hit = (vcount == 10'(VBLANK_LINE)) && (hcount == '0);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push alongside it.
  assign push = push_req && !flush_req && (!full || pop);
  assign drop = push_req && !flush_req && full && !pop;

  assign status_word = {overflow, (state == WAIT_VB), {(30-LEVEL_W){1'b0}}, level};

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cmd_next   = '0;
    swap_inc   = 1'b0;
    if (flush_req) begin
      state_next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          // Entering WAIT_VB ignores a vblank that is already present, so the flip lands next frame.
          if (!empty) begin
            if (head_swap) begin
              state_next = WAIT_VB;
            end else begin
              pop      = 1'b1;
              cmd_next = head;
            end
          end
        end
        WAIT_VB: begin
          if (vblank_hit && !empty) begin
            pop        = 1'b1;
            cmd_next   = head;
            swap_inc   = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      swap_count <= '0;
      cmd_out    <= '0;
      readdata   <= '0;
    end else begin
      state   <= state_next;
      cmd_out <= cmd_next;
      if (flush_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
        level <= level + LEVEL_W'(push) - LEVEL_W'(pop);
      end
      if (swap_inc) swap_count <= swap_count + 32'd1;
      // A drop on the same edge as a status read wins, so no overflow event is lost.
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
      if (chipselect && read) begin
        unique case (address)
          2'd1:    readdata <= status_word;
          2'd2:    readdata <= swap_count;
          default: readdata <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
  end

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// Bench for sprite_cmd_dispatcher: directed table, multi-cycle corner sequences and random traffic
// compared against a queue-based reference model.
module tb_sprite_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [1:0]  address;
  logic [31:0] writedata, readdata, cmd_out;
  logic [9:0]  hcount, vcount;

  always #5 clk = ~clk;

  sprite_cmd_dispatcher #(.FIFO_DEPTH(64), .LEVEL_W(7), .VBLANK_LINE(480)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount), .cmd_out(cmd_out)
  );

  // Reference model state
  logic [31:0] mq[$];
  bit          m_hold, m_ovf;
  logic [31:0] m_swaps, m_cmd, m_rd;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        c, w, r;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_cmd;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[7];

  function automatic void model_reset();
    mq.delete();
    m_hold  = 0;
    m_ovf   = 0;
    m_swaps = 0;
    m_cmd   = 0;
    m_rd    = 0;
  endfunction

  // Applies one clock edge worth of behaviour to the model using the inputs currently driven.
  function automatic void model_edge();
    logic [31:0] nc = 32'h0;
    bit flush = chipselect && write && address == 2'd3;
    bit push  = chipselect && write && address == 2'd0;
    bit rs    = chipselect && read;
    bit vb    = (vcount == 10'd480) && (hcount == 10'd0);
    if (rs) begin
      if (address == 2'd1)      m_rd = {m_ovf, m_hold, 23'b0, 7'(mq.size())};
      else if (address == 2'd2) m_rd = m_swaps;
      else                      m_rd = 32'h0;
      if (address == 2'd1) m_ovf = 0;
    end
    if (flush) begin
      mq.delete();
      m_hold = 0;
    end else begin
      if (mq.size() > 0) begin
        if (!m_hold) begin
          if (mq[0][20:17] == 4'hF) m_hold = 1;
          else nc = mq.pop_front();
        end else if (vb) begin
          nc = mq.pop_front();
          m_swaps = m_swaps + 1;
          m_hold = 0;
        end
      end
      if (push) begin
        if (mq.size() < 64) mq.push_back(writedata);
        else m_ovf = 1;
      end
    end
    m_cmd = nc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic r, input logic [1:0] a,
                      input logic [31:0] wd);
    chipselect = c; write = w; read = r; address = a; writedata = wd;
    model_edge();
    @(posedge clk); #1;
    check("cmd_out_model", cmd_out, m_cmd);
    check("readdata_model", readdata, m_rd);
    chipselect = 0; write = 0; read = 0; address = 0;
  endtask

  task automatic idle(); step(0, 0, 0, 2'd0, 32'h0); endtask
  task automatic push_w(input logic [31:0] wd); step(1, 1, 0, 2'd0, wd); endtask
  task automatic rd(input logic [1:0] a); step(1, 0, 1, a, 32'h0); endtask

  localparam logic [31:0] W0 = 32'h04020011, W1 = 32'h08020022, W2 = 32'h0C020033, W3 = 32'h10020044;
  localparam logic [31:0] WA = 32'h04020101, WB = 32'h08020202, SW = 32'h141E2000;

  initial begin
    reset = 1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
    hcount = 10'd5; vcount = 10'd100;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd", cmd_out, 32'h0);
    check("reset_readdata", readdata, 32'h0);
    reset = 0;

    // First word latency
    repeat (6) idle();
    push_w(32'h28200005);
    check("first_push_cmd", cmd_out, 32'h0);
    idle();
    check("first_word_out", cmd_out, 32'h28200005);
    idle();
    check("first_word_gone", cmd_out, 32'h0);

    // Back-to-back table
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0, W0, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, W1, W0,    1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd0, W2, W1,    1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd0, W3, W2,    1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0, W3, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b1, 32'h0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd);
      check($sformatf("tbl%0d_cmd", i), cmd_out, tbl[i].exp_cmd);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
    end

    // Swap held until vblank
    push_w(WA);
    push_w(SW);
    check("swap_first_word", cmd_out, WA);
    push_w(WB);
    check("swap_held_cmd", cmd_out, 32'h0);
    rd(2'd1);
    check("swap_held_status", readdata, 32'h40000002);
    repeat (5) idle();
    check("swap_still_held", cmd_out, 32'h0);
    vcount = 10'd480; hcount = 10'd0;
    idle();
    check("swap_released", cmd_out, SW);
    hcount = 10'd1;
    idle();
    check("after_swap_word", cmd_out, WB);
    idle();
    check("after_swap_idle", cmd_out, 32'h0);
    rd(2'd2);
    check("swap_count_one", readdata, 32'h1);

    // Swap reaching head while vblank already true waits for the next occurrence
    vcount = 10'd480; hcount = 10'd0;
    push_w(SW);
    idle();
    check("vb_present_no_release", cmd_out, 32'h0);
    hcount = 10'd1;
    idle();
    rd(2'd1);
    check("vb_present_status", readdata, 32'h40000001);
    hcount = 10'd0;
    idle();
    check("vb_next_release", cmd_out, SW);
    hcount = 10'd1;
    idle();

    // Overflow while stalled on a swap
    vcount = 10'd100; hcount = 10'd5;
    push_w(SW);
    for (int i = 0; i < 70; i++) push_w(32'h00020000 | 32'(i));
    rd(2'd1);
    check("ovf_status_set", readdata, 32'hC0000040);
    rd(2'd1);
    check("ovf_status_cleared", readdata, 32'h40000040);
    step(1, 1, 0, 2'd3, 32'h0);
    rd(2'd1);
    check("ovf_flush_status", readdata, 32'h0);

    // Flush with 10 entries while waiting
    push_w(SW);
    for (int i = 0; i < 9; i++) push_w(32'h00020100 | 32'(i));
    rd(2'd1);
    check("flush10_before", readdata, 32'h4000000A);
    step(1, 1, 0, 2'd3, 32'h0);
    rd(2'd1);
    check("flush10_after", readdata, 32'h0);
    vcount = 10'd480; hcount = 10'd0;
    idle();
    check("flush10_no_swap", cmd_out, 32'h0);
    hcount = 10'd1;
    idle();
    rd(2'd2);
    check("flush10_swap_count", readdata, 32'h2);

    // Reset mid-burst
    vcount = 10'd100; hcount = 10'd5;
    push_w(W0);
    push_w(W1);
    push_w(W2);
    push_w(W3);
    #2 reset = 1;
    #1;
    check("midreset_cmd", cmd_out, 32'h0);
    check("midreset_readdata", readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 0;
    rd(2'd1);
    check("midreset_level", readdata, 32'h0);
    rd(2'd2);
    check("midreset_swaps", readdata, 32'h0);
    push_w(W3);
    idle();
    check("midreset_push_ok", cmd_out, W3);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int op;
      logic [31:0] wd;
      if ($urandom_range(0, 15) == 0) begin
        vcount = 10'd480; hcount = 10'd0;
      end else begin
        vcount = 10'($urandom_range(0, 524));
        hcount = 10'($urandom_range(1, 799));
      end
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) wd[20:17] = 4'hF;
      else if (wd[20:17] == 4'hF) wd[20:17] = 4'h1;
      op = $urandom_range(0, 99);
      if (op < 60)      push_w(wd);
      else if (op < 70) rd(2'd1);
      else if (op < 76) rd(2'd2);
      else if (op < 77) step(1, 1, 0, 2'd3, 32'h0);
      else if (op < 79) rd(2'($urandom_range(0, 1) * 3));
      else if (op < 81) step(1, 1, 0, 2'd1, wd);
      else              idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
